// File: rtl/simd_mem_responder.sv
// simd_mem_responder: memory-side responder for the SIMD CPU core.
// Holds instruction RAM (IMEM) and data RAM (DMEM). After reset it clears DMEM,
// then serves instruction, scalar and four-lane reads with one cycle of latency.
// It also accepts host preloads and scalar stores.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   inst_addr/instruction_out instruction fetch (registered output)
//   data_addr/data_out        scalar data read (registered output)
//   data_addr0..3/data_out0..3 vector lane reads, low LANE_W bits (registered)
//   ld_valid/ld_ready/ld_sel/ld_addr/ld_wdata  host preload handshake
//   st_en/st_addr/st_data     scalar store port
//   init_done                 high once the DMEM clear has finished
module simd_mem_responder #(
  parameter int unsigned IADDR_W = 10,
  parameter int unsigned IDATA_W = 13,
  parameter int unsigned DADDR_W = 4,
  parameter int unsigned DDATA_W = 16,
  parameter int unsigned LANE_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IADDR_W-1:0] inst_addr,
  output logic [IDATA_W-1:0] instruction_out,
  input  logic [DADDR_W-1:0] data_addr,
  output logic [DDATA_W-1:0] data_out,
  input  logic [DADDR_W-1:0] data_addr0,
  input  logic [DADDR_W-1:0] data_addr1,
  input  logic [DADDR_W-1:0] data_addr2,
  input  logic [DADDR_W-1:0] data_addr3,
  output logic [LANE_W-1:0]  data_out0,
  output logic [LANE_W-1:0]  data_out1,
  output logic [LANE_W-1:0]  data_out2,
  output logic [LANE_W-1:0]  data_out3,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic               ld_sel,
  input  logic [IADDR_W-1:0] ld_addr,
  input  logic [DDATA_W-1:0] ld_wdata,
  input  logic               st_en,
  input  logic [DADDR_W-1:0] st_addr,
  input  logic [DDATA_W-1:0] st_data,
  output logic               init_done
);

  localparam int unsigned IMEM_D = 1 << IADDR_W;
  localparam int unsigned DMEM_D = 1 << DADDR_W;
  localparam int unsigned CNT_W  = DADDR_W + 1;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         state;
  logic [0:0]         state_nxt;
  logic [CNT_W-1:0]   clr_cnt;
  logic               ld_fire;
  logic               st_fire;

  logic [IDATA_W-1:0] imem [IMEM_D];
  logic [DDATA_W-1:0] dmem [DMEM_D];

  // Write qualifiers; ld_ready is only high in RUN, and nothing commits while rst is high.
  assign ld_fire = ld_valid && ld_ready && !rst;
  assign st_fire = st_en && (state == S_RUN) && !rst;

  // Next-state logic: leave INIT after clearing the last DMEM entry.
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (clr_cnt == CNT_W'(DMEM_D - 1)) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  // State, clear counter, handshake flags and registered read ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_INIT;
      clr_cnt         <= '0;
      ld_ready        <= 1'b0;
      init_done       <= 1'b0;
      instruction_out <= '0;
      data_out        <= '0;
      data_out0       <= '0;
      data_out1       <= '0;
      data_out2       <= '0;
      data_out3       <= '0;
    end else begin
      state     <= state_nxt;
      ld_ready  <= (state_nxt == S_RUN);
      init_done <= (state_nxt == S_RUN);
      if (state == S_INIT) clr_cnt <= clr_cnt + CNT_W'(1);
      if (state == S_RUN) begin
        instruction_out <= imem[inst_addr];
        data_out        <= dmem[data_addr];
        data_out0       <= dmem[data_addr0][LANE_W-1:0];
        data_out1       <= dmem[data_addr1][LANE_W-1:0];
        data_out2       <= dmem[data_addr2][LANE_W-1:0];
        data_out3       <= dmem[data_addr3][LANE_W-1:0];
      end else begin
        instruction_out <= '0;
        data_out        <= '0;
        data_out0       <= '0;
        data_out1       <= '0;
        data_out2       <= '0;
        data_out3       <= '0;
      end
    end
  end

  // IMEM has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (ld_fire && !ld_sel) imem[ld_addr] <= ld_wdata[IDATA_W-1:0];
  end

  // DMEM: cleared during INIT; in RUN the store is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT) begin
        dmem[clr_cnt[DADDR_W-1:0]] <= '0;
      end else begin
        if (ld_fire && ld_sel) dmem[ld_addr[DADDR_W-1:0]] <= ld_wdata;
        if (st_fire) dmem[st_addr] <= st_data;
      end
    end
  end

endmodule

// File: tb/tb_simd_mem_responder.sv
// Self-checking bench for simd_mem_responder: a behavioural model checks every cycle,
// with directed hand sequences, a table of vectors and randomized traffic on top.
module tb_simd_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  inst_addr;
  logic [12:0] instruction_out;
  logic [3:0]  data_addr;
  logic [15:0] data_out;
  logic [3:0]  data_addr0, data_addr1, data_addr2, data_addr3;
  logic [3:0]  data_out0, data_out1, data_out2, data_out3;
  logic        ld_valid, ld_ready, ld_sel;
  logic [9:0]  ld_addr;
  logic [15:0] ld_wdata;
  logic        st_en;
  logic [3:0]  st_addr;
  logic [15:0] st_data;
  logic        init_done;

  int checks = 0;
  int failures = 0;

  simd_mem_responder dut (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .instruction_out(instruction_out),
    .data_addr(data_addr), .data_out(data_out),
    .data_addr0(data_addr0), .data_addr1(data_addr1),
    .data_addr2(data_addr2), .data_addr3(data_addr3),
    .data_out0(data_out0), .data_out1(data_out1),
    .data_out2(data_out2), .data_out3(data_out3),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .st_en(st_en), .st_addr(st_addr), .st_data(st_data),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Reference model: memory contents plus "cycles of clearing done" since reset.
  logic [15:0] m_dmem [16];
  logic [12:0] m_imem [1024];
  bit          m_iv   [1024];
  bit          m_run = 1'b0;
  int          m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; inst_addr = '0; data_addr = '0;
    data_addr0 = '0; data_addr1 = '0; data_addr2 = '0; data_addr3 = '0;
    ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_wdata = '0;
    st_en = 1'b0; st_addr = '0; st_data = '0;
  endtask

  // One clock: predict outputs from the model and current inputs, advance, compare.
  task automatic cycle();
    logic [15:0] ed;
    logic [3:0]  el0, el1, el2, el3;
    logic [12:0] ei;
    bit          ci, erdy;
    ed = '0; el0 = '0; el1 = '0; el2 = '0; el3 = '0; ei = '0; ci = 1'b1; erdy = 1'b0;
    if (rst) begin
      m_run = 1'b0;
      m_cnt = 0;
    end else if (!m_run) begin
      m_dmem[m_cnt] = '0;
      m_cnt++;
      m_run = (m_cnt == 16);
      erdy = m_run;
    end else begin
      ed  = m_dmem[data_addr];
      el0 = m_dmem[data_addr0][3:0];
      el1 = m_dmem[data_addr1][3:0];
      el2 = m_dmem[data_addr2][3:0];
      el3 = m_dmem[data_addr3][3:0];
      ci  = m_iv[inst_addr];
      ei  = m_imem[inst_addr];
      erdy = 1'b1;
      if (ld_valid) begin
        if (ld_sel) m_dmem[ld_addr[3:0]] = ld_wdata;
        else begin
          m_imem[ld_addr] = ld_wdata[12:0];
          m_iv[ld_addr] = 1'b1;
        end
      end
      if (st_en) m_dmem[st_addr] = st_data;
    end
    @(posedge clk);
    #1;
    chk("model_data_out", 32'(data_out), 32'(ed));
    chk("model_lanes", 32'({data_out3, data_out2, data_out1, data_out0}),
        32'({el3, el2, el1, el0}));
    if (ci) chk("model_instruction", 32'(instruction_out), 32'(ei));
    chk("model_ld_ready", 32'(ld_ready), 32'(erdy));
    chk("model_init_done", 32'(init_done), 32'(erdy));
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 40) begin
      cycle();
      n++;
    end
  endtask

  typedef struct packed {
    logic        ldv;
    logic        lds;
    logic [9:0]  lda;
    logic [15:0] ldd;
    logic        ste;
    logic [3:0]  sta;
    logic [15:0] std;
    logic [3:0]  da;
    logic [15:0] la;     // lane k address in bits [4k+3:4k]
    logic        cd;
    logic [15:0] exp_d;
    logic        cl;
    logic [15:0] exp_l;  // lane k expectation in bits [4k+3:4k]
  } vec_t;

  vec_t tbl [13];

  initial begin
    int n;
    idle();

    // Vectors: lane reads, store/preload collisions, read-during-write.
    tbl[0]  = '{1'b1, 1'b1, 10'h002, 16'h00A7, 1'b0, 4'h0, 16'h0, 4'h0, 16'h0000, 1'b0, 16'h0, 1'b0, 16'h0};
    tbl[1]  = '{1'b1, 1'b1, 10'h003, 16'h0003, 1'b0, 4'h0, 16'h0, 4'h0, 16'h0000, 1'b0, 16'h0, 1'b0, 16'h0};
    tbl[2]  = '{1'b1, 1'b1, 10'h004, 16'hFFF5, 1'b0, 4'h0, 16'h0, 4'h0, 16'h0000, 1'b0, 16'h0, 1'b0, 16'h0};
    tbl[3]  = '{1'b1, 1'b1, 10'h005, 16'h1238, 1'b0, 4'h0, 16'h0, 4'h0, 16'h0000, 1'b0, 16'h0, 1'b0, 16'h0};
    tbl[4]  = '{1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 4'h0, 16'h0, 4'h0, 16'h5432, 1'b0, 16'h0, 1'b1, 16'h8537};
    tbl[5]  = '{1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 4'h0, 16'h0, 4'h0, 16'h4444, 1'b0, 16'h0, 1'b1, 16'h5555};
    tbl[6]  = '{1'b1, 1'b1, 10'h209, 16'h1234, 1'b1, 4'h9, 16'hBEEF, 4'h0, 16'h0000, 1'b0, 16'h0, 1'b0, 16'h0};
    tbl[7]  = '{1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 4'h0, 16'h0, 4'h9, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'h0};
    tbl[8]  = '{1'b1, 1'b1, 10'h00A, 16'h1234, 1'b1, 4'h9, 16'hBEEF, 4'h9, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'h0};
    tbl[9]  = '{1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 4'h0, 16'h0, 4'hA, 16'h00A9, 1'b1, 16'h1234, 1'b1, 16'h004F};
    tbl[10] = '{1'b1, 1'b1, 10'h007, 16'h0011, 1'b0, 4'h0, 16'h0, 4'h0, 16'h0000, 1'b0, 16'h0, 1'b0, 16'h0};
    tbl[11] = '{1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 4'h7, 16'h0022, 4'h7, 16'h0000, 1'b1, 16'h0011, 1'b0, 16'h0};
    tbl[12] = '{1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 4'h0, 16'h0, 4'h7, 16'h0000, 1'b1, 16'h0022, 1'b0, 16'h0};

    // Reset then clear.
    @(posedge clk); #1;
    rst = 1'b1;
    cycle();
    cycle();
    chk("reset_outputs", 32'({instruction_out, data_out, ld_ready, init_done}), 32'h0);
    rst = 1'b0;
    wait_init(n);
    chk("init_latency", 32'(n), 32'd16);
    chk("ld_ready_after_init", 32'(ld_ready), 32'd1);
    for (int a = 0; a < 16; a++) begin
      data_addr = 4'(a);
      cycle();
      chk("cleared_dmem", 32'(data_out), 32'h0);
    end
    idle();

    // IMEM preload and fetch.
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 10'd5; ld_wdata = 16'h1A41;
    cycle();
    idle();
    inst_addr = 10'd5;
    cycle();
    chk("imem_fetch", 32'(instruction_out), 32'h1A41);
    inst_addr = 10'd6;
    #2;
    chk("fetch_held_until_edge", 32'(instruction_out), 32'h1A41);
    idle();
    cycle();

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      ld_valid = tbl[i].ldv; ld_sel = tbl[i].lds; ld_addr = tbl[i].lda; ld_wdata = tbl[i].ldd;
      st_en = tbl[i].ste; st_addr = tbl[i].sta; st_data = tbl[i].std;
      data_addr = tbl[i].da;
      data_addr0 = tbl[i].la[3:0];   data_addr1 = tbl[i].la[7:4];
      data_addr2 = tbl[i].la[11:8];  data_addr3 = tbl[i].la[15:12];
      cycle();
      if (tbl[i].cd) chk($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(tbl[i].exp_d));
      if (tbl[i].cl) chk($sformatf("vec%0d_lanes", i),
                         32'({data_out3, data_out2, data_out1, data_out0}), 32'(tbl[i].exp_l));
    end
    idle();

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      ld_valid = 1'($urandom);
      ld_sel = 1'($urandom);
      ld_addr = ld_sel ? 10'($urandom) : 10'($urandom_range(0, 15));
      ld_wdata = 16'($urandom);
      st_en = 1'($urandom);
      st_addr = 4'($urandom);
      st_data = 16'($urandom);
      data_addr = 4'($urandom);
      data_addr0 = 4'($urandom); data_addr1 = 4'($urandom);
      data_addr2 = 4'($urandom); data_addr3 = 4'($urandom);
      inst_addr = 10'($urandom_range(0, 15));
      cycle();
    end
    idle();
    wait_init(n);
    chk("run_before_reset_test", 32'(init_done), 32'd1);

    // Reset mid-operation: IMEM retained, DMEM re-cleared, load under rst dropped.
    ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 10'd1; ld_wdata = 16'h5555;
    cycle();
    ld_sel = 1'b0; ld_addr = 10'd0; ld_wdata = 16'h0101;
    cycle();
    rst = 1'b1; ld_wdata = 16'h0777; data_addr = 4'd1;
    cycle();
    chk("rst_mid_outputs",
        32'({instruction_out, data_out, data_out0, ld_ready, init_done}), 32'h0);
    idle();
    wait_init(n);
    chk("reinit_latency", 32'(n), 32'd16);
    data_addr = 4'd1; inst_addr = 10'd0;
    cycle();
    chk("dmem_recleared", 32'(data_out), 32'h0);
    chk("imem_retained", 32'(instruction_out), 32'h0101);
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
